// File: rtl/spi_pkg.sv
// Shared definitions for the config SPI receiver and the readback transmitter.
package spi_pkg;

  localparam logic        SPI_CS_ACTIVE = 1'b0;
  localparam int unsigned CFG_WORD_W    = 32;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    SHIFT = ST_SHIFT,
    DRAIN = ST_DRAIN
  } spi_state_t;

endpackage

// File: rtl/spi_slave_out_if.sv
// SPI pin bundle between an external master and the readback slave.
interface spi_slave_out_if;

  logic cs;
  logic sck;
  logic miso;
  logic miso_oe;

  modport master (output cs, sck, input miso, miso_oe);
  modport slave  (input cs, sck, output miso, miso_oe);

endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin plus a history flop for edge detection.
module spi_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      hist_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~hist_q;
  assign fall  = ~level & hist_q;

endmodule

// File: rtl/spi_slave_out.sv
// SPI mode-0 slave transmitter: shifts a status word captured at CS assertion out on miso, MSB first.
module spi_slave_out
  import spi_pkg::*;
#(
  parameter int unsigned WIDTH       = CFG_WORD_W,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  spi_slave_out_if.slave   spi,
  input  logic [WIDTH-1:0] in_buf,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic cs_level, cs_rise, cs_fall;
  logic sck_level, sck_rise, sck_fall;
  logic cs_start, cs_stop;
  logic unused_levels;

  spi_state_t       state_q;
  logic [WIDTH-1:0] shift_q;
  logic [CNT_W-1:0] count_q;
  logic             oe_q;

  // cs resets to its active level so a CS held low through reset does not look like a new assertion
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(SPI_CS_ACTIVE)) u_cs_sync (
    .clk   (clk),
    .reset (reset),
    .din   (spi.cs),
    .level (cs_level),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck_sync (
    .clk   (clk),
    .reset (reset),
    .din   (spi.sck),
    .level (sck_level),
    .rise  (sck_rise),
    .fall  (sck_fall)
  );

  assign unused_levels = cs_level ^ sck_level;
  assign cs_start      = (SPI_CS_ACTIVE == 1'b0) ? cs_fall : cs_rise;
  assign cs_stop       = (SPI_CS_ACTIVE == 1'b0) ? cs_rise : cs_fall;

  // Transfer FSM; CS edges take priority over sck edges in the same cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      count_q <= '0;
      oe_q    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cs_start) begin
            state_q <= SHIFT;
            shift_q <= in_buf;
            count_q <= '0;
            oe_q    <= 1'b1;
            busy    <= 1'b1;
          end
        end
        SHIFT: begin
          if (cs_stop) begin
            state_q <= IDLE;
            shift_q <= '0;
            count_q <= '0;
            oe_q    <= 1'b0;
            busy    <= 1'b0;
          end else if (sck_rise) begin
            if (count_q == CNT_W'(WIDTH - 1)) begin
              state_q <= DRAIN;
              count_q <= CNT_W'(WIDTH);
              shift_q <= '0;
              done    <= 1'b1;
            end else begin
              count_q <= count_q + CNT_W'(1);
            end
          end else if (sck_fall) begin
            shift_q <= {shift_q[WIDTH-2:0], 1'b0};
          end
        end
        DRAIN: begin
          if (cs_stop) begin
            state_q <= IDLE;
            shift_q <= '0;
            count_q <= '0;
            oe_q    <= 1'b0;
            busy    <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // miso is the shift register MSB, so it is zero whenever the register is cleared
  assign spi.miso    = shift_q[WIDTH-1];
  assign spi.miso_oe = oe_q;

endmodule

// File: tb/tb_spi_slave_out.sv
// Self-checking bench for spi_slave_out: a mode-0 master at clk/8 with a scoreboard of expected words.
module tb_spi_slave_out;

  logic        clk;
  logic        reset;
  logic [31:0] in_buf;
  logic        busy;
  logic        done;

  spi_slave_out_if bus ();

  spi_slave_out #(.WIDTH(32), .SYNC_STAGES(2)) dut (
    .clk    (clk),
    .reset  (reset),
    .spi    (bus),
    .in_buf (in_buf),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;
  int done_at  = 0;
  int rise_idx = 0;
  logic [31:0] exp_q[$];

  // Count done pulses and remember which sck rising edge preceded the latest one
  always @(negedge clk) begin
    if (done) begin
      done_cnt = done_cnt + 1;
      done_at  = rise_idx;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cs_assert(input logic [31:0] word);
    in_buf = word;
    @(negedge clk);
    bus.cs = 1'b0;
    wait_clk(8);
  endtask

  task automatic cs_release();
    @(negedge clk);
    bus.cs = 1'b1;
  endtask

  // Mode-0 master: raise sck, sample miso, lower sck; 4 clk per half period
  task automatic run_sck(input int n, input int chg_at, input logic [31:0] chg_val,
                         output logic [63:0] bits, output int oe_hits, output int busy_hits);
    bits = '0; oe_hits = 0; busy_hits = 0; rise_idx = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.sck = 1'b1;
      rise_idx = rise_idx + 1;
      bits = {bits[62:0], bus.miso};
      if (bus.miso_oe) oe_hits++;
      if (busy) busy_hits++;
      wait_clk(3);
      @(negedge clk);
      bus.sck = 1'b0;
      if (i + 1 == chg_at) in_buf = chg_val;
      wait_clk(3);
    end
  endtask

  task automatic full_read(input string tag, input logic [31:0] word, input int chg_at,
                           input logic [31:0] chg_val);
    logic [63:0] bits;
    logic [31:0] exp;
    int oe_hits, busy_hits, d0;
    exp_q.push_back(word);
    d0 = done_cnt;
    cs_assert(word);
    check({tag, "_oe_start"}, 64'(bus.miso_oe), 64'd1);
    run_sck(32, chg_at, chg_val, bits, oe_hits, busy_hits);
    exp = exp_q.pop_front();
    check({tag, "_word"}, bits, 64'(exp));
    check({tag, "_done_cnt"}, 64'(done_cnt - d0), 64'd1);
    check({tag, "_oe_held"}, 64'(oe_hits), 64'd32);
    cs_release();
    wait_clk(3);
    check({tag, "_idle_outs"}, 64'({bus.miso, bus.miso_oe, busy, done}), 64'd0);
    wait_clk(2);
  endtask

  initial begin
    logic [63:0] bits;
    int oe_hits, busy_hits, d0;

    bus.cs = 1'b1; bus.sck = 1'b0; in_buf = '0; reset = 1'b1;
    wait_clk(3);
    check("rst_miso", 64'(bus.miso), 64'd0);
    check("rst_oe", 64'(bus.miso_oe), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    reset = 1'b0;
    wait_clk(5);

    // Basic read and snapshot
    full_read("basic", 32'hA5C3_0F12, 0, 32'h0);
    full_read("snapshot", 32'h1234_5678, 3, 32'hFFFF_FFFF);

    // Abort after 17 rising edges
    d0 = done_cnt;
    cs_assert(32'hCAFE_BABE);
    run_sck(17, 0, 32'h0, bits, oe_hits, busy_hits);
    check("abort_prefix", bits, 64'(17'h1_95FD));
    cs_release();
    wait_clk(3);
    check("abort_outs", 64'({bus.miso, bus.miso_oe, busy}), 64'd0);
    check("abort_no_done", 64'(done_cnt - d0), 64'd0);
    wait_clk(3);
    full_read("after_abort", 32'h0BAD_F00D, 0, 32'h0);

    // Overclock: 40 sck cycles in one CS window
    d0 = done_cnt;
    cs_assert(32'h8000_0001);
    run_sck(40, 0, 32'h0, bits, oe_hits, busy_hits);
    check("over_word", 64'(bits[39:8]), 64'h8000_0001);
    check("over_tail", 64'(bits[7:0]), 64'd0);
    check("over_done_cnt", 64'(done_cnt - d0), 64'd1);
    check("over_done_edge", 64'(done_at), 64'd32);
    check("over_oe", 64'(oe_hits), 64'd40);
    cs_release();
    wait_clk(5);

    // Reset mid-transfer at bit 10 with CS held low
    d0 = done_cnt;
    cs_assert(32'h1357_9BDF);
    run_sck(10, 0, 32'h0, bits, oe_hits, busy_hits);
    check("rmid_prefix", bits, 64'(10'h04D));
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rmid_outs", 64'({bus.miso, bus.miso_oe, busy, done}), 64'd0);
    reset = 1'b0;
    run_sck(22, 0, 32'h0, bits, oe_hits, busy_hits);
    check("rmid_dead_oe", 64'(oe_hits), 64'd0);
    check("rmid_dead_busy", 64'(busy_hits), 64'd0);
    check("rmid_dead_miso", bits, 64'd0);
    check("rmid_no_done", 64'(done_cnt - d0), 64'd0);
    cs_release();
    wait_clk(5);
    full_read("after_rst", 32'h2468_ACE0, 0, 32'h0);

    // Idle noise: sck toggling with CS high
    d0 = done_cnt;
    run_sck(20, 0, 32'h0, bits, oe_hits, busy_hits);
    check("idle_oe", 64'(oe_hits), 64'd0);
    check("idle_busy", 64'(busy_hits), 64'd0);
    check("idle_done", 64'(done_cnt - d0), 64'd0);
    check("idle_miso", bits, 64'd0);
    check("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
